// File: rtl/coleta_votos.sv
// Vote collector: gathers one vote per voter for a session, closes when every voter
// has voted or the session timer expires, then holds the vote vector until acknowledged.
module coleta_votos #(
   parameter int unsigned TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inicio,
   input  logic [2:0] voto_valido,
   input  logic [2:0] voto_valor,
   input  logic       lido,
   output logic [2:0] V,
   output logic [2:0] votou,
   output logic       pronto,
   output logic [1:0] estado
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'b00,
      VOTACAO = 2'b01,
      FECHADO = 2'b10
   } estado_t;

   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

   estado_t    estado_q;
   logic [7:0] cnt;
   logic [2:0] aceita;
   logic [2:0] votou_prox;
   logic [2:0] v_prox;

   // Only a voter's first strobe in a session is accepted.
   always_comb begin
      aceita     = voto_valido & ~votou;
      votou_prox = votou | aceita;
      v_prox     = (V & ~aceita) | (voto_valor & aceita);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= OCIOSO;
         V        <= 3'b000;
         votou    <= 3'b000;
         pronto   <= 1'b0;
         cnt      <= 8'd0;
      end else begin
         unique case (estado_q)
            OCIOSO: begin
               V      <= 3'b000;
               votou  <= 3'b000;
               pronto <= 1'b0;
               if (inicio) begin
                  estado_q <= VOTACAO;
                  cnt      <= 8'd0;
               end
            end
            VOTACAO: begin
               V     <= v_prox;
               votou <= votou_prox;
               cnt   <= cnt + 8'd1;
               if (votou_prox == 3'b111 || cnt == CNT_MAX) begin
                  estado_q <= FECHADO;
                  pronto   <= 1'b1;
               end
            end
            FECHADO: begin
               if (lido) begin
                  estado_q <= OCIOSO;
                  V        <= 3'b000;
                  votou    <= 3'b000;
                  pronto   <= 1'b0;
               end
            end
            default: begin
               estado_q <= OCIOSO;
               V        <= 3'b000;
               votou    <= 3'b000;
               pronto   <= 1'b0;
            end
         endcase
      end
   end

   assign estado = estado_q;

endmodule

// File: tb/tb_coleta_votos.sv
// Directed, table-driven bench for coleta_votos with TIMEOUT=8, plus an
// asynchronous-reset sequence.
module tb_coleta_votos;

   logic       clk;
   logic       rst;
   logic       inicio;
   logic [2:0] voto_valido;
   logic [2:0] voto_valor;
   logic       lido;
   logic [2:0] V;
   logic [2:0] votou;
   logic       pronto;
   logic [1:0] estado;

   int total = 0;
   int bad   = 0;

   coleta_votos #(.TIMEOUT(8)) dut (
      .clk(clk),
      .rst(rst),
      .inicio(inicio),
      .voto_valido(voto_valido),
      .voto_valor(voto_valor),
      .lido(lido),
      .V(V),
      .votou(votou),
      .pronto(pronto),
      .estado(estado)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       ini;
      logic [2:0] vv;
      logic [2:0] vval;
      logic       ack;
      logic [1:0] e;
      logic [2:0] v;
      logic [2:0] vot;
      logic       p;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic ini, input logic [2:0] vv, input logic [2:0] vval,
                      input logic ack, input logic [1:0] e, input logic [2:0] v,
                      input logic [2:0] vot, input logic p);
      vec_t r;
      r.ini = ini; r.vv = vv; r.vval = vval; r.ack = ack;
      r.e = e; r.v = v; r.vot = vot; r.p = p;
      tbl.push_back(r);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] e, input logic [2:0] v,
                          input logic [2:0] vot, input logic p);
      chk({tag, ".estado"}, int'(estado), int'(e));
      chk({tag, ".V"}, int'(V), int'(v));
      chk({tag, ".votou"}, int'(votou), int'(vot));
      chk({tag, ".pronto"}, int'(pronto), int'(p));
   endtask

   task automatic drive(input logic ini, input logic [2:0] vv, input logic [2:0] vval,
                        input logic ack);
      inicio = ini; voto_valido = vv; voto_valor = vval; lido = ack;
      @(posedge clk);
      #1;
      inicio = 1'b0; voto_valido = 3'b000; voto_valor = 3'b000; lido = 1'b0;
   endtask

   initial begin
      rst = 1'b1; inicio = 1'b0; voto_valido = 3'b000; voto_valor = 3'b000; lido = 1'b0;

      // Three separate votes 1,0,1; inicio/strobes ignored while closed
      add(1, 3'b000, 3'b000, 0, 2'b01, 3'b000, 3'b000, 0);
      add(0, 3'b001, 3'b001, 0, 2'b01, 3'b001, 3'b001, 0);
      add(0, 3'b010, 3'b000, 0, 2'b01, 3'b001, 3'b011, 0);
      add(0, 3'b100, 3'b100, 0, 2'b10, 3'b101, 3'b111, 1);
      add(1, 3'b111, 3'b000, 0, 2'b10, 3'b101, 3'b111, 1);
      add(0, 3'b000, 3'b000, 1, 2'b00, 3'b000, 3'b000, 0);
      // All three at once
      add(1, 3'b000, 3'b000, 0, 2'b01, 3'b000, 3'b000, 0);
      add(0, 3'b111, 3'b110, 0, 2'b10, 3'b110, 3'b111, 1);
      add(0, 3'b000, 3'b000, 1, 2'b00, 3'b000, 3'b000, 0);
      // First vote wins; lido in VOTACAO ignored
      add(1, 3'b000, 3'b000, 0, 2'b01, 3'b000, 3'b000, 0);
      add(0, 3'b001, 3'b001, 0, 2'b01, 3'b001, 3'b001, 0);
      add(0, 3'b000, 3'b000, 1, 2'b01, 3'b001, 3'b001, 0);
      add(0, 3'b001, 3'b000, 0, 2'b01, 3'b001, 3'b001, 0);
      add(0, 3'b110, 3'b000, 0, 2'b10, 3'b001, 3'b111, 1);
      add(0, 3'b000, 3'b000, 1, 2'b00, 3'b000, 3'b000, 0);
      // Timeout after 8 cycles with only voter 1; mid-session inicio ignored
      add(1, 3'b000, 3'b000, 0, 2'b01, 3'b000, 3'b000, 0);
      add(0, 3'b010, 3'b010, 0, 2'b01, 3'b010, 3'b010, 0);
      add(0, 3'b000, 3'b000, 0, 2'b01, 3'b010, 3'b010, 0);
      add(1, 3'b000, 3'b000, 0, 2'b01, 3'b010, 3'b010, 0);
      add(0, 3'b000, 3'b000, 0, 2'b01, 3'b010, 3'b010, 0);
      add(0, 3'b000, 3'b000, 0, 2'b01, 3'b010, 3'b010, 0);
      add(0, 3'b000, 3'b000, 0, 2'b01, 3'b010, 3'b010, 0);
      add(0, 3'b000, 3'b000, 0, 2'b01, 3'b010, 3'b010, 0);
      add(0, 3'b000, 3'b000, 0, 2'b10, 3'b010, 3'b010, 1);
      add(0, 3'b000, 3'b000, 0, 2'b10, 3'b010, 3'b010, 1);
      add(0, 3'b000, 3'b000, 1, 2'b00, 3'b000, 3'b000, 0);
      // Vote accepted on the timeout edge itself
      add(1, 3'b000, 3'b000, 0, 2'b01, 3'b000, 3'b000, 0);
      for (int k = 0; k < 7; k++) add(0, 3'b000, 3'b000, 0, 2'b01, 3'b000, 3'b000, 0);
      add(0, 3'b100, 3'b100, 0, 2'b10, 3'b100, 3'b100, 1);
      add(0, 3'b000, 3'b000, 1, 2'b00, 3'b000, 3'b000, 0);

      #12;
      chk_all("reset_hold", 2'b00, 3'b000, 3'b000, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_all("idle_after_reset", 2'b00, 3'b000, 3'b000, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].ini, tbl[i].vv, tbl[i].vval, tbl[i].ack);
         chk_all($sformatf("vec%0d", i), tbl[i].e, tbl[i].v, tbl[i].vot, tbl[i].p);
      end

      // Asynchronous reset mid-session with V=011
      drive(1, 3'b000, 3'b000, 0);
      drive(0, 3'b011, 3'b011, 0);
      chk_all("pre_async_rst", 2'b01, 3'b011, 3'b011, 0);
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 2'b00, 3'b000, 3'b000, 0);
      @(posedge clk);
      #1;
      chk_all("rst_held", 2'b00, 3'b000, 3'b000, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 3'b000, 3'b000, 0);
      chk_all("resume_start", 2'b01, 3'b000, 3'b000, 0);
      drive(0, 3'b111, 3'b001, 0);
      chk_all("resume_close", 2'b10, 3'b001, 3'b111, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
